poly_seq_engine: RTL and testbench
==================================

// Module: poly_seq_engine
// PURPOSE
//  Parametrised multi-voice step sequencer and square-wave synth; next generation of the single-voice audio engine.
//  Fully synchronous: clk-domain tick enables, no derived clocks. Steps through a pattern of programmable loop length.
//  Fetches per-voice half-periods from an external pattern ROM via step index, gates notes, mixes voices to 1-bit delta-sigma audio.
//  Sits between the pattern ROM and the audio output pin.
// PARAMETERS
//  NUM_VOICES      2    number of square-wave voices (1..8)
//  HP_W            7    half-period width per voice, in synth ticks; hp==0 means rest
//  STEP_W          7    step index width
//  SYNTH_DIV_LOG2  10   synth_tick every 2**SYNTH_DIV_LOG2 clk cycles
//  SEQ_DIV_LOG2    17   seq_tick every 2**SEQ_DIV_LOG2 clk cycles (> SYNTH_DIV_LOG2)
//  TICKS_PER_STEP  20   seq_ticks per step
//  GATE_TICKS      10   seq_ticks per step with note sounding (<= TICKS_PER_STEP)
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  asynchronous, active-low reset
//  enable       in   1                  run when 1; hold/mute when 0
//  restart      in   1                  sync pulse: return to step 0
//  loop_last    in   STEP_W             last step before wrap to 0
//  note_hp      in   NUM_VOICES*HP_W    half-periods for current step; voice v at [v*HP_W +: HP_W]
//  step         out  STEP_W             current step index (ROM address)
//  step_strobe  out  1                  1-clk pulse when step advances or wraps
//  gate         out  1                  1 while tick_ctr < GATE_TICKS
//  audio        out  1                  delta-sigma mixed output
// BEHAVIOUR
//  Reset: prescaler, tick_ctr, step, phase ctrs, squares, mix acc all 0; step_strobe=0, gate=1 (tick_ctr=0), audio=0.
//  Prescaler: free-running SEQ_DIV_LOG2-bit counter, advances only when enable=1.
//   synth_tick = (low SYNTH_DIV_LOG2 bits all 1) & enable. seq_tick = (all bits 1) & enable.
//  Step ctrl on seq_tick: tick_ctr==TICKS_PER_STEP-1 -> tick_ctr=0, step=(step>=loop_last)?0:step+1, step_strobe=1 next cycle;
//   else tick_ctr+1. loop_last lowered below step -> wrap to 0 at next step boundary.
//  gate = (tick_ctr < GATE_TICKS), combinational from register.
//  Voice v on synth_tick:
//   hp==0 or gate==0 -> phase=0, sq=0.
//   else phase>=hp-1 -> phase=0, sq toggles; else phase+1.
//   Compare is >=, so hp shrink mid-note toggles on next tick; no lockup. hp sampled each tick, not latched.
//  Mixer, every clk: s = popcount(sq[]) in 0..NUM_VOICES.
//   a = acc+s; a>=NUM_VOICES -> audio=1, acc=a-NUM_VOICES; else audio=0, acc=a.
//   Density of audio = s/NUM_VOICES exactly over time; NUM_VOICES=1 degenerates to plain square.
//  enable=0: all counters, step, phases hold; sq forced 0; acc cleared; audio=0; step_strobe=0.
//  restart=1 (priority over enable and ticks): prescaler, tick_ctr, step, phases, sq, acc -> 0; step_strobe=1 next cycle.
//  Async reset mid-note: immediate return to reset values; first seq_tick after release is 2**SEQ_DIV_LOG2 clks later.
//  Widths: acc is clog2(NUM_VOICES+1) bits; phase is HP_W bits; no other arithmetic can overflow.
// STRUCTURE
//  Shared package audio_pkg: NOTE_* half-period constants (e.g. NOTE_B1=100, NOTE_C3=47, NOTE_A3=28), REST=0.
//   Pattern ROM functions also live there and are instantiated outside this block.
//  Sub-module sq_voice (one per voice, generate loop): inputs clk, rst_n, tick, clear, hp; output sq.
//  Step ctrl, prescaler and mixer stay inline in poly_seq_engine.
// TESTING (params SYNTH_DIV_LOG2=2, SEQ_DIV_LOG2=4, TICKS_PER_STEP=4, GATE_TICKS=2, NUM_VOICES=2)
//  1. Reset, enable=1, loop_last=2 -> step_strobe every 64 clks; step 0,1,2,0; gate high 32 clks of each 64.
//  2. hp={0,3} (voice0=3), gated -> voice0 toggles every 12 clks; mix audio density 50% while sq=1, 0% else.
//  3. hp={3,3} -> both sq equal; audio tracks sq exactly (s=2 -> 1, s=0 -> 0).
//  4. enable=0 mid-step for 100 clks -> step/tick_ctr unchanged, audio=0; resume continues exact tick phase.
//  5. restart pulse at step 2, tick 3 -> next cycle step=0, step_strobe=1, prescaler=0; next strobe 64 clks later.
//  6. hp 7->2 mid-note with phase=5 -> toggle on next synth_tick, then every 2 ticks; rst_n low mid-note -> all outputs 0 at once.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants: note half-periods in synth ticks, mixer sizing helper
// and a small demo pattern ROM for the block that drives note_hp.
package audio_pkg;

    localparam int REST    = 0;
    localparam int NOTE_B1 = 100;
    localparam int NOTE_C3 = 47;
    localparam int NOTE_E3 = 37;
    localparam int NOTE_G3 = 31;
    localparam int NOTE_A3 = 28;

    // Accumulator width that holds 0..num_voices for the delta-sigma mixer.
    function automatic int mix_acc_w(input int num_voices);
        return $clog2(num_voices + 1);
    endfunction

    // Two-voice demo pattern: voice 0 in the low 7 bits, voice 1 in the high 7 bits.
    function automatic logic [13:0] demo_pattern(input logic [6:0] step);
        logic [13:0] row;
        row = '0;
        case (step[1:0])
            2'd0: row = {7'(NOTE_B1), 7'(NOTE_C3)};
            2'd1: row = {7'(REST),    7'(NOTE_E3)};
            2'd2: row = {7'(NOTE_B1), 7'(NOTE_G3)};
            default: row = {7'(REST), 7'(NOTE_A3)};
        endcase
        return row;
    endfunction

endpackage

// File: rtl/poly_seq_engine_if.sv
// Control/ROM/audio bundle between the sequencer engine and its surroundings.
interface poly_seq_engine_if #(
    parameter int NUM_VOICES = 2,
    parameter int HP_W       = 7,
    parameter int STEP_W     = 7
);
    // No valid/ready: step is the ROM address and is valid every cycle; step_strobe
    // pulses for one clk when it changes. note_hp must follow step and is sampled
    // on every synth tick, never latched.
    logic                       enable;
    logic                       restart;
    logic [STEP_W-1:0]          loop_last;
    logic [NUM_VOICES*HP_W-1:0] note_hp;
    logic [STEP_W-1:0]          step;
    logic                       step_strobe;
    logic                       gate;
    logic                       audio;

    modport master (
        output enable, restart, loop_last, note_hp,
        input  step, step_strobe, gate, audio
    );

    modport slave (
        input  enable, restart, loop_last, note_hp,
        output step, step_strobe, gate, audio
    );
endinterface

// File: rtl/sq_voice.sv
// One square-wave voice: toggles every hp synth ticks, silent when hp is zero.
module sq_voice #(
    parameter int HP_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            clear,
    input  logic [HP_W-1:0] hp,
    output logic            sq
);
    logic [HP_W-1:0] phase;

    // >= rather than == so a shorter hp arriving mid-note toggles at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            sq    <= 1'b0;
        end else if (clear) begin
            phase <= '0;
            sq    <= 1'b0;
        end else if (tick) begin
            if (hp == '0) begin
                phase <= '0;
                sq    <= 1'b0;
            end else if (phase >= hp - 1'b1) begin
                phase <= '0;
                sq    <= ~sq;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end
endmodule

// File: rtl/poly_seq_engine.sv
// Multi-voice step sequencer: prescaled tick enables, step/gate control,
// per-voice square generators and a first-order delta-sigma mixer.
module poly_seq_engine
    import audio_pkg::*;
#(
    parameter int NUM_VOICES     = 2,
    parameter int HP_W           = 7,
    parameter int STEP_W         = 7,
    parameter int SYNTH_DIV_LOG2 = 10,
    parameter int SEQ_DIV_LOG2   = 17,
    parameter int TICKS_PER_STEP = 20,
    parameter int GATE_TICKS     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    poly_seq_engine_if.slave    bus
);
    localparam int TICK_W = $clog2(TICKS_PER_STEP + 1);
    localparam int ACC_W  = mix_acc_w(NUM_VOICES);
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [TICK_W-1:0] GATE_LIM  = TICK_W'(GATE_TICKS);
    localparam logic [SUM_W-1:0]  NV_S      = SUM_W'(NUM_VOICES);

    logic [SEQ_DIV_LOG2-1:0] pre;
    logic [TICK_W-1:0]       tick_ctr;
    logic [STEP_W-1:0]       step_q;
    logic                    strobe_q;
    logic                    synth_tick;
    logic                    seq_tick;
    logic                    gate;

    assign synth_tick = bus.enable & (&pre[SYNTH_DIV_LOG2-1:0]);
    assign seq_tick   = bus.enable & (&pre);
    assign gate       = (tick_ctr < GATE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre      <= '0;
            tick_ctr <= '0;
            step_q   <= '0;
            strobe_q <= 1'b0;
        end else if (bus.restart) begin
            pre      <= '0;
            tick_ctr <= '0;
            step_q   <= '0;
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= 1'b0;
            if (bus.enable) pre <= pre + 1'b1;
            if (seq_tick) begin
                if (tick_ctr == TICK_LAST) begin
                    tick_ctr <= '0;
                    // >= so a loop_last lowered below step still wraps here.
                    step_q   <= (step_q >= bus.loop_last) ? '0 : step_q + 1'b1;
                    strobe_q <= 1'b1;
                end else begin
                    tick_ctr <= tick_ctr + 1'b1;
                end
            end
        end
    end

    logic [NUM_VOICES-1:0] sq;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [HP_W-1:0] hp_v;
        assign hp_v = gate ? bus.note_hp[v*HP_W +: HP_W] : '0;
        sq_voice #(.HP_W(HP_W)) u_voice (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (synth_tick),
            .clear (bus.restart),
            .hp    (hp_v),
            .sq    (sq[v])
        );
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             audio_next;
    logic [SUM_W-1:0] live_sum;
    logic [SUM_W-1:0] mix_sum;

    always_comb begin
        live_sum   = SUM_W'($countones(sq & {NUM_VOICES{bus.enable}}));
        mix_sum    = {1'b0, acc} + live_sum;
        audio_next = 1'b0;
        acc_next   = ACC_W'(mix_sum);
        if (mix_sum >= NV_S) begin
            audio_next = 1'b1;
            acc_next   = ACC_W'(mix_sum - NV_S);
        end
    end

    logic audio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            audio_q <= 1'b0;
        end else if (bus.restart || !bus.enable) begin
            acc     <= '0;
            audio_q <= 1'b0;
        end else begin
            acc     <= acc_next;
            audio_q <= audio_next;
        end
    end

    assign bus.step        = step_q;
    assign bus.step_strobe = strobe_q;
    assign bus.gate        = gate;
    assign bus.audio       = audio_q;
endmodule

// File: tb/tb_poly_seq_engine.sv
// Bench for poly_seq_engine: cycle model built from the step/voice/mixer rules,
// directed scenarios with hand-computed counts, then randomized traffic.
module tb_poly_seq_engine;
    localparam int NV   = 2;
    localparam int HPW  = 7;
    localparam int SW   = 7;
    localparam int SYN  = 2;
    localparam int SEQ  = 4;
    localparam int TPS  = 4;
    localparam int GT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_seq_engine_if #(.NUM_VOICES(NV), .HP_W(HPW), .STEP_W(SW)) bus ();

    poly_seq_engine #(
        .NUM_VOICES(NV), .HP_W(HPW), .STEP_W(SW),
        .SYNTH_DIV_LOG2(SYN), .SEQ_DIV_LOG2(SEQ),
        .TICKS_PER_STEP(TPS), .GATE_TICKS(GT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt, m_tick, m_step, m_strobe, m_acc, m_audio;
    int m_phase[NV];
    int m_sq[NV];
    bit chk_en = 1'b0;

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; m_step = 0; m_strobe = 0; m_acc = 0; m_audio = 0;
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_sq[v]    = 0;
        end
    endtask

    task automatic model_clock();
        int s, a, hp;
        bit gate_now, synth, seqt;
        if (bus.restart) begin
            model_reset();
            m_strobe = 1;
            return;
        end
        if (!bus.enable) begin
            m_strobe = 0; m_acc = 0; m_audio = 0;
            return;
        end
        s = 0;
        for (int v = 0; v < NV; v++) s += m_sq[v];
        a = m_acc + s;
        m_audio = (a >= NV) ? 1 : 0;
        m_acc   = (a >= NV) ? a - NV : a;
        gate_now = (m_tick < GT);
        synth    = ((m_cnt % (1 << SYN)) == (1 << SYN) - 1);
        seqt     = ((m_cnt % (1 << SEQ)) == (1 << SEQ) - 1);
        if (synth) begin
            for (int v = 0; v < NV; v++) begin
                hp = gate_now ? int'(bus.note_hp[v*HPW +: HPW]) : 0;
                if (hp == 0) begin
                    m_phase[v] = 0; m_sq[v] = 0;
                end else if (m_phase[v] >= hp - 1) begin
                    m_phase[v] = 0; m_sq[v] = 1 - m_sq[v];
                end else begin
                    m_phase[v]++;
                end
            end
        end
        m_strobe = 0;
        if (seqt) begin
            if (m_tick == TPS - 1) begin
                m_tick   = 0;
                m_step   = (m_step >= int'(bus.loop_last)) ? 0 : m_step + 1;
                m_strobe = 1;
            end else begin
                m_tick++;
            end
        end
        m_cnt++;
    endtask

    always @(posedge clk) if (rst_n) model_clock();
    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (chk_en) begin
            check("step",   int'(bus.step),        m_step);
            check("strobe", int'(bus.step_strobe), m_strobe);
            check("gate",   int'(bus.gate),        (m_tick < GT) ? 1 : 0);
            check("audio",  int'(bus.audio),       m_audio);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic count_window(input int n, output int ones, output int strobes);
        ones = 0; strobes = 0;
        repeat (n) begin
            @(negedge clk);
            ones    += int'(bus.audio);
            strobes += int'(bus.step_strobe);
        end
    endtask

    int ones, strobes, ghi, nstr, held_step, gap;
    int first_str;
    int str_steps[3];

    initial begin
        model_reset();
        bus.enable    = 1'b1;
        bus.restart   = 1'b0;
        bus.loop_last = SW'(2);
        bus.note_hp   = '0;
        chk_en        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_step",  int'(bus.step), 0);
        check("rst_gate",  int'(bus.gate), 1);
        check("rst_audio", int'(bus.audio), 0);
        rst_n = 1'b1;

        // Step timing with loop_last=2: strobes at 64, 128, 192.
        nstr = 0; ghi = 0; first_str = -1;
        for (int i = 1; i <= 192; i++) begin
            @(negedge clk);
            if (bus.step_strobe) begin
                if (nstr < 3) str_steps[nstr] = int'(bus.step);
                if (first_str < 0) first_str = i;
                nstr++;
            end
            if (i <= 64 && bus.gate) ghi++;
        end
        check("strobe_count", nstr, 3);
        check("first_strobe_clk", first_str, 64);
        check("wrap_seq0", str_steps[0], 1);
        check("wrap_seq1", str_steps[1], 2);
        check("wrap_seq2", str_steps[2], 0);
        check("gate_high_clks", ghi, 32);

        // One voice hp=3: sq high for 12 clks in the gated half, mixed at 50%.
        bus.loop_last = '0;
        bus.note_hp   = {7'd0, 7'd3};
        do_restart();
        count_window(64, ones, strobes);
        check("one_voice_ones", ones, 6);

        // Both voices hp=3: audio follows sq exactly.
        bus.note_hp = {7'd3, 7'd3};
        do_restart();
        count_window(64, ones, strobes);
        check("two_voice_ones", ones, 12);

        // hp 7 -> 2 with phase at 5: toggle on next tick, then every 2 ticks.
        bus.note_hp = {7'd0, 7'd7};
        do_restart();
        repeat (20) @(negedge clk);
        bus.note_hp = {7'd0, 7'd2};
        count_window(44, ones, strobes);
        check("hp_shrink_ones", ones, 4);

        // Enable low for 100 clks mid-step.
        bus.loop_last = SW'(2);
        bus.note_hp   = {7'd3, 7'd5};
        do_restart();
        repeat (70) @(negedge clk);
        held_step  = int'(bus.step);
        bus.enable = 1'b0;
        count_window(100, ones, strobes);
        check("hold_audio", ones, 0);
        check("hold_strobes", strobes, 0);
        check("hold_step", int'(bus.step), held_step);
        bus.enable = 1'b1;
        repeat (200) @(negedge clk);

        // Restart at step 2, tick 3; the next strobe must follow 64 clks later.
        do_restart();
        repeat (180) @(negedge clk);
        check("pre_restart_step", int'(bus.step), 2);
        do_restart();
        check("restart_step", int'(bus.step), 0);
        check("restart_strobe", int'(bus.step_strobe), 1);
        gap = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.step_strobe) begin
                gap = i;
                break;
            end
        end
        check("restart_gap", gap, 64);

        // Async reset mid-note: outputs return at once, between clock edges.
        bus.loop_last = SW'(3);
        bus.note_hp   = {7'd2, 7'd3};
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_step",   int'(bus.step), 0);
        check("async_strobe", int'(bus.step_strobe), 0);
        check("async_audio",  int'(bus.audio), 0);
        check("async_gate",   int'(bus.gate), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        repeat (20000) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                for (int v = 0; v < NV; v++)
                    bus.note_hp[v*HPW +: HPW] =
                        ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 9));
            end
            if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 1999) == 0) bus.loop_last = SW'($urandom_range(0, 5));
            bus.restart = ($urandom_range(0, 999) == 0);
        end
        bus.restart = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
